// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbitration logic.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Arbiter FSM: ARB searches for a requester, HOLD owns the FIFO write port.
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Ceiling log2 for sizing index and counter fields; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set bit of req starting at start, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] cand;

    // Walk the cyclic order backwards so the last hit kept is the first in order.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos  = (int'(start) + k) % N;
            cand = IDX_W'(pos);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ requesters.
// Latency: 1 ARB cycle from request to grant, then one word per cycle while granted.
// Backpressure: fifo_w_full and clk_en combinationally drop req_ready/fifo_w_en; full never releases a grant.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int BURST_MAX = 4,
    localparam int ID_W      = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_w_en,
    output logic [DATA_W-1:0]         fifo_w_data,
    input  logic                      fifo_w_full,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = (clog2(BURST_MAX + 1) < 1) ? 1 : clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]  grant_id_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              cur_valid;
    logic              xfer;

    // Unpack the flat data bus so the grant mux is a plain array index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_valid   = req_valid[grant_id];
    assign xfer        = (state == HOLD) && clk_en && cur_valid && !fifo_w_full;
    assign grant_valid = (state == HOLD);

    // Next-state and write-port drive; full/clk_en gate the port in the same cycle.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_id_nxt  = grant_id;
        burst_cnt_nxt = burst_cnt;
        req_ready     = '0;
        fifo_w_en     = 1'b0;
        fifo_w_data   = '0;
        case (state)
            ARB: begin
                if (pick_found) begin
                    grant_id_nxt  = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                req_ready[grant_id] = clk_en && !fifo_w_full;
                fifo_w_en           = xfer;
                fifo_w_data         = data_arr[grant_id];
                if ((xfer && burst_cnt == LAST_BEAT) || !cur_valid) begin
                    // Burst exhausted or requester idle: hand the next search to g+1.
                    rr_ptr_nxt    = ID_W'((int'(grant_id) + 1) % NUM_REQ);
                    burst_cnt_nxt = '0;
                    state_nxt     = ARB;
                end else if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // State registers; everything freezes while clk_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else if (clk_en) begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_id_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written corner sequences.
// Latency: checks each cycle's combinational outputs half a period after inputs are applied.
// Backpressure: exercises fifo_w_full and clk_en stalls; a write scoreboard stands in for the FIFO.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam logic [31:0] DA = 32'hA3A2A1A0;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      clk_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_w_en;
    logic [DATA_W-1:0]         fifo_w_data;
    logic                      fifo_w_full;
    logic                      grant_valid;
    logic [1:0]                grant_id;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .fifo_w_full (fifo_w_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        full;
        logic        w_en;
        logic [3:0]  rdy;
        logic        gv;
        logic [1:0]  gid;
        logic [7:0]  wdat;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_wr[$];
    logic [7:0] got_wr[$];
    int         tests = 0;
    int         fails = 0;

    // Stand-in for the FIFO: capture every word it would accept at the next edge.
    always @(negedge clk) begin
        if (reset && clk_en && fifo_w_en && !fifo_w_full) got_wr.push_back(fifo_w_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ce, input logic [3:0] vld, input logic [31:0] dat,
                       input logic full, input logic w_en, input logic [3:0] rdy,
                       input logic gv, input logic [1:0] gid, input logic [7:0] wdat,
                       input int n);
        vec_t v;
        v.ce = ce; v.vld = vld; v.dat = dat; v.full = full;
        v.w_en = w_en; v.rdy = rdy; v.gv = gv; v.gid = gid; v.wdat = wdat;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic exp_words(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) exp_wr.push_back(w);
    endtask

    task automatic step(input logic ce, input logic [3:0] vld);
        @(posedge clk);
        #1;
        clk_en    = ce;
        req_valid = vld;
        @(negedge clk);
    endtask

    initial begin
        // Single requester, three words, then idle release (rr_ptr -> 1).
        add(1, 4'b0001, 32'h0F, 0, 0, 4'b0000, 0, 0, 8'h00, 1);
        add(1, 4'b0001, 32'h0F, 0, 1, 4'b0001, 1, 0, 8'h0F, 1);
        add(1, 4'b0001, 32'h45, 0, 1, 4'b0001, 1, 0, 8'h45, 1);
        add(1, 4'b0001, 32'h2A, 0, 1, 4'b0001, 1, 0, 8'h2A, 1);
        add(1, 4'b0000, 32'h2A, 0, 0, 4'b0001, 1, 0, 8'h2A, 1);
        add(1, 4'b0000, 32'h2A, 0, 0, 4'b0000, 0, 0, 8'h00, 1);
        // All requesters busy: bursts of 4 in order 1,2,3,0 with one ARB bubble each.
        add(1, 4'b1111, DA, 0, 0, 4'b0000, 0, 0, 8'h00, 1);
        add(1, 4'b1111, DA, 0, 1, 4'b0010, 1, 1, 8'hA1, 4);
        add(1, 4'b1111, DA, 0, 0, 4'b0000, 0, 1, 8'h00, 1);
        add(1, 4'b1111, DA, 0, 1, 4'b0100, 1, 2, 8'hA2, 4);
        add(1, 4'b1111, DA, 0, 0, 4'b0000, 0, 2, 8'h00, 1);
        add(1, 4'b1111, DA, 0, 1, 4'b1000, 1, 3, 8'hA3, 4);
        add(1, 4'b1111, DA, 0, 0, 4'b0000, 0, 3, 8'h00, 1);
        add(1, 4'b1111, DA, 0, 1, 4'b0001, 1, 0, 8'hA0, 4);
        // Requester 2 stalled by full for 5 cycles mid-burst; burst count preserved.
        add(1, 4'b0100, DA, 0, 0, 4'b0000, 0, 0, 8'h00, 1);
        add(1, 4'b0100, DA, 0, 1, 4'b0100, 1, 2, 8'hA2, 1);
        add(1, 4'b0100, DA, 1, 0, 4'b0000, 1, 2, 8'hA2, 5);
        add(1, 4'b0100, DA, 0, 1, 4'b0100, 1, 2, 8'hA2, 3);
        // Requester 3 frozen by clk_en=0 for 3 cycles mid-burst.
        add(1, 4'b1000, DA, 0, 0, 4'b0000, 0, 2, 8'h00, 1);
        add(1, 4'b1000, DA, 0, 1, 4'b1000, 1, 3, 8'hA3, 1);
        add(0, 4'b1000, DA, 0, 0, 4'b0000, 1, 3, 8'hA3, 3);
        add(1, 4'b1000, DA, 0, 1, 4'b1000, 1, 3, 8'hA3, 3);
        add(1, 4'b0000, DA, 0, 0, 4'b0000, 0, 3, 8'h00, 1);

        exp_wr.push_back(8'h0F); exp_wr.push_back(8'h45); exp_wr.push_back(8'h2A);
        exp_words(8'hA1, 4); exp_words(8'hA2, 4); exp_words(8'hA3, 4); exp_words(8'hA0, 4);
        exp_words(8'hA2, 4); exp_words(8'hA3, 4);
        exp_words(8'hA1, 2); exp_words(8'hA3, 1); exp_words(8'hA1, 1);

        // Reset state while reset is held low.
        reset = 1'b0; clk_en = 1'b1; req_valid = '0; req_data = DA; fifo_w_full = 1'b0;
        #12;
        chk("reset_w_en", 32'(fifo_w_en), 32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_gv", 32'(grant_valid), 32'h0);
        chk("reset_gid", 32'(grant_id), 32'h0);
        chk("reset_wdata", 32'(fifo_w_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table: apply each row for one cycle and compare the combinational outputs.
        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk);
            #1;
            clk_en      = vecs[r].ce;
            req_valid   = vecs[r].vld;
            req_data    = vecs[r].dat;
            fifo_w_full = vecs[r].full;
            @(negedge clk);
            chk($sformatf("row%0d {w_en,rdy,gv,gid,wdat}", r),
                32'({fifo_w_en, req_ready, grant_valid, grant_id, fifo_w_data}),
                32'({vecs[r].w_en, vecs[r].rdy, vecs[r].gv, vecs[r].gid, vecs[r].wdat}));
        end

        // Requester 1 drops after 2 words; rr_ptr=2 so requester 3 wins next.
        req_data = DA;
        step(1, 4'b0010);
        chk("drop_arb_gv", 32'(grant_valid), 32'h0);
        step(1, 4'b0010);
        chk("drop_w1", 32'({fifo_w_en, grant_id, fifo_w_data}), 32'({1'b1, 2'd1, 8'hA1}));
        step(1, 4'b0010);
        chk("drop_w2", 32'({fifo_w_en, grant_id, fifo_w_data}), 32'({1'b1, 2'd1, 8'hA1}));
        step(1, 4'b1000);
        chk("drop_release", 32'({fifo_w_en, grant_valid, grant_id}), 32'({1'b0, 1'b1, 2'd1}));
        step(1, 4'b1000);
        chk("drop_rearb_gv", 32'(grant_valid), 32'h0);
        step(1, 4'b1000);
        chk("next_grant_3", 32'({fifo_w_en, grant_valid, grant_id, fifo_w_data}),
            32'({1'b1, 1'b1, 2'd3, 8'hA3}));

        // Reset mid-burst: outputs clear before any further clock edge.
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst {w_en,rdy,gv,gid,wdat}",
            32'({fifo_w_en, req_ready, grant_valid, grant_id, fifo_w_data}), 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b1010;
        // rr_ptr restarted at 0, so requester 1 beats requester 3.
        step(1, 4'b1010);
        chk("post_rst_grant", 32'({fifo_w_en, grant_valid, grant_id, fifo_w_data}),
            32'({1'b1, 1'b1, 2'd1, 8'hA1}));
        step(1, 4'b0000);
        chk("post_rst_idle_w_en", 32'(fifo_w_en), 32'h0);
        step(1, 4'b0000);

        // Everything the FIFO would have stored, in order.
        chk("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            chk($sformatf("wr_word%0d", i), 32'(got_wr[i]), 32'(exp_wr[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one `fifo` instance between NUM_REQ requesters.
- Arbitration is round-robin with a bounded burst length.
- Each requester uses a valid/ready handshake.
- The arbiter drives the FIFO's w_en/w_data and honours w_full and clk_en, so the FIFO never takes a write while full.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_W, 8, data word width; must match the FIFO's data_word_size
- BURST_MAX, 4, maximum words written per grant (≥1)
- ID_W, clog2(NUM_REQ), width of grant_id (derived)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable, shared with the FIFO
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- fifo_w_en  out  1  to FIFO w_en
- fifo_w_data  out  DATA_W  to FIFO w_data
- fifo_w_full  in  1  from FIFO w_full
- grant_valid  out  1  a grant is currently held
- grant_id  out  ID_W  index of the granted requester

Behaviour:
- Reset (reset=0, async):
  - state=ARB, rr_ptr=0, grant_id=0, burst_cnt=0.
  - grant_valid=0, req_ready=0, fifo_w_en=0, fifo_w_data=0.
- clk_en=0:
  - All registers hold.
  - fifo_w_en=0 and req_ready=0, combinationally.
- State ARB (grant_valid=0):
  - If clk_en and any req_valid: pick the first valid index searching rr_ptr, rr_ptr+1, … wrapping mod NUM_REQ.
  - Load grant_id, set burst_cnt=0, go to HOLD.
  - No transfer happens in the ARB cycle, so grant-to-first-write latency is 1 cycle.
- State HOLD (grant_valid=1, g=grant_id):
  - xfer = clk_en & req_valid[g] & !fifo_w_full.
  - req_ready[g] = clk_en & !fifo_w_full. All other req_ready bits are 0.
  - fifo_w_en = xfer; fifo_w_data = req_data[g], combinational mux.
  - This path is combinational so full takes effect in the same cycle; the FIFO never sees w_en with w_full=1.
  - burst_cnt increments on each xfer.
  - Release when clk_en and either of:
    - xfer and burst_cnt==BURST_MAX-1, or
    - !req_valid[g] (requester went idle).
  - On release: rr_ptr=(g+1) mod NUM_REQ, state=ARB, burst_cnt=0.
- Full boundary: while fifo_w_full=1, no transfer occurs. The grant, burst_cnt and rr_ptr hold; full alone never releases a grant.
- Simultaneous events: a requester asserting valid in the same cycle as release competes in the next ARB cycle from the new rr_ptr.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0; the search order is strictly cyclic.
- Reset mid-burst: an in-flight word is dropped and outputs go to reset values immediately. Requesters must re-present data.
- Throughput: at most BURST_MAX words per BURST_MAX+1 cycles per grant (one ARB bubble per grant).
- Protocol rule: req_data must stay stable while req_valid is high and req_ready is low.

Decomposition:
- Shared package/header `fifo_pkg`:
  - state encoding (ARB=1'b0, HOLD=1'b1)
  - clog2 function
  - default DATA_W
- Sub-module `rr_pick`: purely combinational round-robin search. Inputs are req vector and start pointer; outputs are found flag and index. It is reusable by a future read-side scheduler.
- The top module holds the FSM, counter, pointer and data mux, and contains no FIFO instance.

Test Plan:
- After reset release, req_valid=4'b0001, data 15, 69, 42 (3 words) → grant_id=0; fifo_w_en high for exactly 3 cycles starting 1 cycle after valid; the FIFO reads back 15, 69, 42.
- All four requesters valid continuously, BURST_MAX=4 → grant order 0,1,2,3,0; exactly 4 writes per grant; 1 idle cycle between grants.
- Requester 2 granted, fifo_w_full forced high for 5 cycles mid-burst → fifo_w_en=0 and req_ready=0 for those 5 cycles; grant_id stays 2; burst resumes at the same burst_cnt; total word count is preserved.
- clk_en=0 for 3 cycles during HOLD → no writes, all registers frozen; operation resumes unchanged when clk_en returns.
- Requester 1 drops valid after 2 of 4 words, requester 3 valid → release; next grant is 3 with rr_ptr=2; requester 0 is skipped because it is not valid.
- Assert reset low mid-burst → outputs zero asynchronously, before the next clock edge; after release, arbitration restarts from rr_ptr=0.
